// File: rtl/mips_pkg.sv
// Shared MIPS encodings: next-PC select codes used by control_unit and fetch_unit,
// plus the fetch FSM state type.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCC_W = 3;

    localparam logic [PCC_W-1:0] PC_NEXT   = 3'b000;
    localparam logic [PCC_W-1:0] PC_JUMP   = 3'b001;
    localparam logic [PCC_W-1:0] PC_JR     = 3'b010;
    localparam logic [PCC_W-1:0] PC_BRANCH = 3'b011;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_EXEC  = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    // Branch immediate, sign-extended and scaled to a byte offset.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch_unit and imem.
interface fetch_unit_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC mux: sequential, jump, register-indirect and branch targets.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [PCC_W-1:0] pc_control_i,
    input  logic [XLEN-1:0]  rs_data_i,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [XLEN-1:0]  next_pc_o,
    output logic             misaligned_o
);

    assign pc_plus4_o = pc_i + XLEN'(4);

    // Codes 3'b1xx fall through to sequential fetch.
    always_comb begin
        next_pc_o = pc_plus4_o;
        case (pc_control_i)
            PC_JUMP:   next_pc_o = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
            PC_JR:     next_pc_o = rs_data_i;
            PC_BRANCH: next_pc_o = pc_plus4_o + branch_offset(instr_i[15:0]);
            default:   next_pc_o = pc_plus4_o;
        endcase
    end

    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: fetches over req/ack, holds the instruction
// for execute, and advances the PC only when execute reports completion.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic [XLEN-1:0]   instruction_o,
    output logic              instr_valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   pc_plus4_c_o,
    input  logic [PCC_W-1:0]  pc_control_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic              exec_done_i,
    output logic              fault_o,
    output logic [XLEN-1:0]   retired_count_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] retired_q, retired_d;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;

    next_pc_calc u_next_pc_calc (
        .pc_i         (pc_q),
        .instr_i      (instr_q),
        .pc_control_i (pc_control_i),
        .rs_data_i    (rs_data_i),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (next_pc),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FS_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            req_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            req_q     <= req_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and datapath updates; a misaligned target retires but halts in place.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        case (state_q)
            FS_IDLE: state_d = FS_FETCH;
            FS_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = FS_EXEC;
                end
            end
            FS_EXEC: begin
                if (exec_done_i) begin
                    retired_d = retired_q + XLEN'(1);
                    valid_d   = 1'b0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = FS_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FS_FETCH;
                    end
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_IDLE;
        endcase
        req_d = (state_d == FS_FETCH);
    end

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = pc_q;
    assign instruction_o   = instr_q;
    assign instr_valid_o   = valid_q;
    assign pc_o            = pc_q;
    assign pc_plus4_c_o    = pc_plus4;
    assign fault_o         = fault_q;
    assign retired_count_o = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: tied-high streaming table, per-instruction
// vector table with an expected-PC scoreboard, fault/halt and mid-fetch reset.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instruction, pc, pc_plus4, rs_data, retired_count;
    logic        instr_valid, exec_done, fault;
    logic [2:0]  pc_control;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] model_retired;

    always #5 clk = ~clk;

    fetch_unit_if imem_if ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (imem_if),
        .instruction_o   (instruction),
        .instr_valid_o   (instr_valid),
        .pc_o            (pc),
        .pc_plus4_c_o    (pc_plus4),
        .pc_control_i    (pc_control),
        .rs_data_i       (rs_data),
        .exec_done_i     (exec_done),
        .fault_o         (fault),
        .retired_count_o (retired_count)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] retired;
    } stream_t;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        logic [2:0]  pcc;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_if.imem_req), 32'd0);
        chk({tag, "_addr"}, imem_if.imem_addr, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'h4);
        chk({tag, "_instr"}, instruction, 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_retired"}, retired_count, 32'd0);
    endtask

    // One full instruction: fetch with optional wait states, stray ack in EXEC, then retire.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        logic [31:0] exp_a;
        n = 0;
        while (!imem_if.imem_req && n < 10) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_req_wait", idx), 32'(imem_if.imem_req), 32'd1);
        exp_a = (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : 32'hDEAD_BEEF;
        chk($sformatf("v%0d_fetch_addr", idx), imem_if.imem_addr, exp_a);
        chk($sformatf("v%0d_pc", idx), pc, exp_a);
        chk($sformatf("v%0d_pc_plus4", idx), pc_plus4, exp_a + 32'd4);
        for (int w = 0; w < v.waits; w++) begin
            imem_if.imem_rdata = $urandom;
            tick();
            chk($sformatf("v%0d_wait%0d_req", idx, w), 32'(imem_if.imem_req), 32'd1);
            chk($sformatf("v%0d_wait%0d_addr", idx, w), imem_if.imem_addr, exp_a);
            chk($sformatf("v%0d_wait%0d_valid", idx, w), 32'(instr_valid), 32'd0);
        end
        imem_if.imem_rdata = v.rdata;
        imem_if.imem_ack = 1'b1;
        tick();
        imem_if.imem_ack = 1'b0;
        chk($sformatf("v%0d_instr", idx), instruction, v.rdata);
        chk($sformatf("v%0d_valid_hi", idx), 32'(instr_valid), 32'd1);
        chk($sformatf("v%0d_req_exec", idx), 32'(imem_if.imem_req), 32'd0);
        imem_if.imem_rdata = ~v.rdata;
        imem_if.imem_ack = 1'b1;
        tick();
        imem_if.imem_ack = 1'b0;
        chk($sformatf("v%0d_instr_held", idx), instruction, v.rdata);
        chk($sformatf("v%0d_valid_held", idx), 32'(instr_valid), 32'd1);
        pc_control = v.pcc;
        rs_data = v.rs;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        pc_control = 3'($urandom);
        rs_data = $urandom;
        model_retired = model_retired + 32'd1;
        chk($sformatf("v%0d_retired", idx), retired_count, model_retired);
        chk($sformatf("v%0d_fault", idx), 32'(fault), 32'(v.exp_fault));
        chk($sformatf("v%0d_valid_lo", idx), 32'(instr_valid), 32'd0);
        if (!v.exp_fault) begin
            exp_pc_q.push_back(v.exp_pc);
            chk($sformatf("v%0d_req_next", idx), 32'(imem_if.imem_req), 32'd1);
        end else begin
            chk($sformatf("v%0d_pc_hold", idx), pc, exp_a);
            chk($sformatf("v%0d_req_halt", idx), 32'(imem_if.imem_req), 32'd0);
        end
    endtask

    stream_t stream[7];
    vec_t    vecs[12];

    initial begin
        stream[0] = '{1'b1, 32'h0, 1'b0, 32'd0};
        stream[1] = '{1'b0, 32'h0, 1'b1, 32'd0};
        stream[2] = '{1'b1, 32'h4, 1'b0, 32'd1};
        stream[3] = '{1'b0, 32'h4, 1'b1, 32'd1};
        stream[4] = '{1'b1, 32'h8, 1'b0, 32'd2};
        stream[5] = '{1'b0, 32'h8, 1'b1, 32'd2};
        stream[6] = '{1'b1, 32'hC, 1'b0, 32'd3};

        vecs[0]  = '{32'h1234_5678, 3, PC_JR,     32'h1000_0010, 32'h1000_0010, 1'b0};
        vecs[1]  = '{32'h0800_0040, 0, PC_JUMP,   32'h0,         32'h1000_0100, 1'b0};
        vecs[2]  = '{32'h0000_0000, 0, PC_JR,     32'h0000_0020, 32'h0000_0020, 1'b0};
        vecs[3]  = '{32'h0000_FFFE, 0, PC_BRANCH, 32'h0,         32'h0000_001C, 1'b0};
        vecs[4]  = '{32'h0000_0000, 1, PC_JR,     32'h0000_0020, 32'h0000_0020, 1'b0};
        vecs[5]  = '{32'h0000_FFFE, 0, PC_NEXT,   32'h0,         32'h0000_0024, 1'b0};
        vecs[6]  = '{32'h0800_0040, 0, 3'b100,    32'h0000_0042, 32'h0000_0028, 1'b0};
        vecs[7]  = '{32'h0000_0000, 2, PC_JR,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[8]  = '{32'h0000_0000, 0, PC_NEXT,   32'h0,         32'h0000_0000, 1'b0};
        vecs[9]  = '{32'h0000_FFFE, 0, PC_BRANCH, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{32'h0800_0040, 0, 3'b111,    32'h0,         32'h0000_0000, 1'b0};
        vecs[11] = '{32'h0000_0000, 0, PC_JR,     32'h0000_0042, 32'h0000_0000, 1'b1};

        imem_if.imem_ack = 1'b0;
        imem_if.imem_rdata = 32'h0;
        exec_done = 1'b0;
        pc_control = PC_NEXT;
        rs_data = 32'h0;

        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs("reset");

        // Streaming with ack and exec_done tied high: two cycles per instruction.
        imem_if.imem_ack = 1'b1;
        imem_if.imem_rdata = 32'h0000_0000;
        exec_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("s%0d_req", k), 32'(imem_if.imem_req), 32'(stream[k].req));
            chk($sformatf("s%0d_addr", k), imem_if.imem_addr, stream[k].addr);
            chk($sformatf("s%0d_valid", k), 32'(instr_valid), 32'(stream[k].valid));
            chk($sformatf("s%0d_retired", k), retired_count, stream[k].retired);
        end
        imem_if.imem_ack = 1'b0;
        exec_done = 1'b0;
        model_retired = 32'd3;
        exp_pc_q.push_back(32'hC);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Halted: ack and exec_done are ignored until reset.
        imem_if.imem_ack = 1'b1;
        exec_done = 1'b1;
        pc_control = PC_NEXT;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("halt%0d_req", k), 32'(imem_if.imem_req), 32'd0);
            chk($sformatf("halt%0d_fault", k), 32'(fault), 32'd1);
            chk($sformatf("halt%0d_pc", k), pc, 32'h0);
            chk($sformatf("halt%0d_retired", k), retired_count, model_retired);
        end
        exec_done = 1'b0;

        // Reset pulse out of HALT; ack held high during reset must be discarded.
        imem_if.imem_rdata = 32'hBAD0_0001;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("halt_rst");
        @(negedge clk);
        imem_if.imem_rdata = 32'hCAFE_0001;
        rst_n = 1'b1;
        tick();
        chk("rel_req", 32'(imem_if.imem_req), 32'd1);
        chk("rel_addr", imem_if.imem_addr, 32'h0);
        chk("rel_instr", instruction, 32'h0);
        tick();
        imem_if.imem_ack = 1'b0;
        chk("rel_capture", instruction, 32'hCAFE_0001);
        chk("rel_valid", 32'(instr_valid), 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("rel_pc", pc, 32'h4);
        chk("rel_req2", 32'(imem_if.imem_req), 32'd1);

        // Asynchronous reset in the middle of a fetch clears everything at once.
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midfetch_rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
